// File: rtl/cam_rgb444_capture.sv
// Camera RGB444 byte-stream capture: pairs bytes into 12-bit pixels, tracks x/y position,
// discards settling frames after enable, and flags malformed lines or frames.
module cam_rgb444_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic [15:0] rgb_data,
    output logic        pixel_valid,
    output logic [9:0]  x_cnt,
    output logic [8:0]  y_cnt,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err
);

    localparam int SKW = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
    localparam logic [10:0]    H_LEN     = 11'(H_ACTIVE);
    localparam logic [8:0]     V_LEN     = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        WAIT   = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic           vs_q, vs_q2, hr_q, hr_q2;
    logic [7:0]     d_q;
    logic           vs_rise, vs_fall, hr_fall;

    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic           phase_q, phase_d;
    logic [3:0]     r_q, r_d;
    logic [10:0]    pix_cnt_q, pix_cnt_d;
    logic [15:0]    rgb_data_q, rgb_data_d;
    logic           pixel_valid_q, pixel_valid_d;
    logic [9:0]     x_cnt_q, x_cnt_d;
    logic [8:0]     y_cnt_q, y_cnt_d;
    logic [8:0]     y_line;
    logic           frame_start_q, frame_start_d;
    logic           frame_done_q, frame_done_d;
    logic           line_err_q, line_err_d;

    function automatic logic [10:0] sat_inc_pix(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_x(input logic [10:0] v);
        return (v > 11'd1023) ? 10'd1023 : v[9:0];
    endfunction

    function automatic logic [8:0] sat_inc_y(input logic [8:0] v);
        return (v == 9'd511) ? v : v + 9'd1;
    endfunction

    // Input stage: one register on the camera pins plus history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            hr_q  <= 1'b0;
            hr_q2 <= 1'b0;
            d_q   <= 8'd0;
        end else begin
            vs_q  <= vsync;
            vs_q2 <= vs_q;
            hr_q  <= href;
            hr_q2 <= hr_q;
            d_q   <= d;
        end
    end

    assign vs_rise = vs_q & ~vs_q2;
    assign vs_fall = ~vs_q & vs_q2;
    assign hr_fall = ~hr_q & hr_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && vs_fall) begin
                    state_d = (SKIP_FRAMES > 0) ? SKIP : ACTIVE;
                end
            end
            SKIP: begin
                if (vs_rise && (skip_cnt_q == SKIP_LAST)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (vs_fall) begin
                    state_d = enable ? ACTIVE : IDLE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        skip_cnt_d    = skip_cnt_q;
        phase_d       = phase_q;
        r_d           = r_q;
        pix_cnt_d     = pix_cnt_q;
        rgb_data_d    = rgb_data_q;
        pixel_valid_d = 1'b0;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        y_line        = y_cnt_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;

        if (state_q == IDLE) begin
            skip_cnt_d = '0;
        end else if ((state_q == SKIP) && vs_rise) begin
            skip_cnt_d = skip_cnt_q + SKW'(1);
        end

        if (state_q == ACTIVE) begin
            if (hr_q) begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    r_d = d_q[3:0];
                end else begin
                    rgb_data_d    = {4'b0000, r_q, d_q};
                    pixel_valid_d = 1'b1;
                    x_cnt_d       = sat_x(pix_cnt_q);
                    pix_cnt_d     = sat_inc_pix(pix_cnt_q);
                    if ((pix_cnt_q == 11'd0) && (y_cnt_q == 9'd0)) begin
                        frame_start_d = 1'b1;
                        line_err_d    = 1'b0;
                    end
                end
            end

            // Line end: an odd byte count or a short/long line marks the frame bad
            if (hr_fall) begin
                if (phase_q || (pix_cnt_q != H_LEN)) begin
                    line_err_d = 1'b1;
                end
                y_line    = sat_inc_y(y_cnt_q);
                phase_d   = 1'b0;
                pix_cnt_d = 11'd0;
            end
            y_cnt_d = y_line;

            // Frame end; href still high here means the line was cut short
            if (vs_rise) begin
                frame_done_d = 1'b1;
                if (hr_q || (y_line != V_LEN)) begin
                    line_err_d = 1'b1;
                end
                y_cnt_d   = 9'd0;
                phase_d   = 1'b0;
                pix_cnt_d = 11'd0;
            end
        end else begin
            phase_d   = 1'b0;
            pix_cnt_d = 11'd0;
            y_cnt_d   = 9'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_cnt_q    <= '0;
            phase_q       <= 1'b0;
            r_q           <= 4'd0;
            pix_cnt_q     <= 11'd0;
            rgb_data_q    <= 16'd0;
            pixel_valid_q <= 1'b0;
            x_cnt_q       <= 10'd0;
            y_cnt_q       <= 9'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            skip_cnt_q    <= skip_cnt_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            pix_cnt_q     <= pix_cnt_d;
            rgb_data_q    <= rgb_data_d;
            pixel_valid_q <= pixel_valid_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
        end
    end

    assign rgb_data    = rgb_data_q;
    assign pixel_valid = pixel_valid_q;
    assign x_cnt       = x_cnt_q;
    assign y_cnt       = y_cnt_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_cam_rgb444_capture.sv
// Scoreboard bench for cam_rgb444_capture with 4x2 frames and two settling frames.
module tb_cam_rgb444_capture;

    localparam int H = 4;
    localparam int V = 2;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        vsync = 1'b1;
    logic        href = 1'b0;
    logic [7:0]  d = 8'd0;
    logic [15:0] rgb_data;
    logic        pixel_valid;
    logic [9:0]  x_cnt;
    logic [8:0]  y_cnt;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;

    cam_rgb444_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK)) dut (
        .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .href(href), .d(d),
        .rgb_data(rgb_data), .pixel_valid(pixel_valid), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rgb;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        fs;
    } pix_t;

    pix_t exp_q[$];
    pix_t obs_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   fs_cnt = 0;
    int   fd_cnt = 0;

    // Observed strobes are collected on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (pixel_valid) obs_q.push_back({rgb_data, x_cnt, y_cnt, frame_start});
        if (frame_start) fs_cnt++;
        if (frame_done) fd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1);
    end

    task automatic send_line(input int nbytes, input bit exp_en, input int y);
        logic [7:0] b;
        logic [7:0] first;
        pix_t       p;
        first = 8'd0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            href = 1'b1;
            d = b;
            if (i % 2 == 0) begin
                first = b;
            end else if (exp_en) begin
                p.rgb = {4'h0, first[3:0], b};
                p.x = 10'(i / 2);
                p.y = 9'(y);
                p.fs = (i == 1) && (y == 0);
                exp_q.push_back(p);
            end
        end
        @(negedge clk);
        href = 1'b0;
        d = 8'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        vsync = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input bit exp_en);
        start_frame();
        send_line(2 * H, exp_en, 0);
        send_line(2 * H, exp_en, 1);
        end_frame();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (rgb_data !== 16'd0) begin n_fail++; $display("FAIL reset_rgb: got %h want 0000", rgb_data); end
        n_tests++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv: got %b want 0", pixel_valid); end
        n_tests++; if (x_cnt !== 10'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", x_cnt); end
        n_tests++; if (y_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", y_cnt); end
        n_tests++; if ({frame_start, frame_done, line_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {frame_start, frame_done, line_err});
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_skip_capture();
        pix_t e, o;
        int   fd0, fs0;
        exp_q.delete(); obs_q.delete();
        fd0 = fd_cnt; fs0 = fs_cnt;
        enable = 1'b1;
        send_frame(0);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL skip1_strobes: got %0d want 0", obs_q.size()); end
        send_frame(0);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL skip2_strobes: got %0d want 0", obs_q.size()); end
        n_tests++; if (fd_cnt != fd0) begin n_fail++; $display("FAIL skip_done: got %0d want 0", fd_cnt - fd0); end
        send_frame(1);
        n_tests++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL cap_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL cap_pixel: got %h want %h", o, e); end
        end
        n_tests++; if (fs_cnt - fs0 != 1) begin n_fail++; $display("FAIL cap_fs: got %0d want 1", fs_cnt - fs0); end
        n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL cap_fd: got %0d want 1", fd_cnt - fd0); end
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL cap_err: got %b want 0", line_err); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pixel_format();
        exp_q.delete(); obs_q.delete();
        start_frame();
        @(negedge clk); href = 1'b1; d = 8'h0A;
        @(negedge clk); d = 8'h5C;
        @(negedge clk);
        n_tests++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL fmt_early: got %b want 0", pixel_valid); end
        d = 8'hFF;
        @(negedge clk);
        n_tests++; if (pixel_valid !== 1'b1 || rgb_data !== 16'h0A5C || x_cnt !== 10'd0 || frame_start !== 1'b1) begin
            n_fail++; $display("FAIL fmt_px0: got pv=%b rgb=%h x=%0d fs=%b want pv=1 rgb=0a5c x=0 fs=1",
                               pixel_valid, rgb_data, x_cnt, frame_start);
        end
        d = 8'h3E;
        @(negedge clk);
        n_tests++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL fmt_gap: got %b want 0", pixel_valid); end
        d = 8'h12;
        @(negedge clk);
        n_tests++; if (pixel_valid !== 1'b1 || rgb_data !== 16'h0F3E || x_cnt !== 10'd1) begin
            n_fail++; $display("FAIL fmt_px1: got pv=%b rgb=%h x=%0d want pv=1 rgb=0f3e x=1", pixel_valid, rgb_data, x_cnt);
        end
        d = 8'h34;
        @(negedge clk); d = 8'h56;
        @(negedge clk); d = 8'h78;
        @(negedge clk); href = 1'b0; d = 8'd0;
        repeat (3) @(negedge clk);
        n_tests++; if (rgb_data !== 16'h0678 || x_cnt !== 10'd3 || y_cnt !== 9'd1) begin
            n_fail++; $display("FAIL fmt_hold: got rgb=%h x=%0d y=%0d want rgb=0678 x=3 y=1", rgb_data, x_cnt, y_cnt);
        end
        send_line(2 * H, 0, 1);
        end_frame();
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL fmt_err: got %b want 0", line_err); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_odd_line();
        pix_t e, o;
        int   fd0;
        exp_q.delete(); obs_q.delete();
        fd0 = fd_cnt;
        start_frame();
        send_line(7, 1, 0);
        n_tests++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL odd_err_set: got %b want 1", line_err); end
        send_line(2 * H, 1, 1);
        end_frame();
        n_tests++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL odd_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL odd_pixel: got %h want %h", o, e); end
        end
        n_tests++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL odd_err_sticky: got %b want 1", line_err); end
        n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL odd_fd: got %0d want 1", fd_cnt - fd0); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_enable_drop();
        pix_t e, o;
        int   fd0;
        exp_q.delete(); obs_q.delete();
        fd0 = fd_cnt;
        start_frame();
        send_line(2 * H, 1, 0);
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL en_err_clear: got %b want 0", line_err); end
        enable = 1'b0;
        send_line(2 * H, 1, 1);
        end_frame();
        n_tests++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL en_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL en_pixel: got %h want %h", o, e); end
        end
        n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL en_fd: got %0d want 1", fd_cnt - fd0); end
        exp_q.delete(); obs_q.delete();
        send_frame(0);
        enable = 1'b1;
        send_frame(0);
        send_frame(0);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL en_idle_skip: got %0d want 0", obs_q.size()); end
        n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL en_idle_fd: got %0d want 1", fd_cnt - fd0); end
        send_frame(1);
        n_tests++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL en_recap_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL en_recap_pixel: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        pix_t e, o;
        int   fd0;
        exp_q.delete(); obs_q.delete();
        start_frame();
        send_line(2 * H, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); href = 1'b1; d = 8'($urandom);
        end
        @(negedge clk);
        n_tests++; if (y_cnt !== 9'd1) begin n_fail++; $display("FAIL rstmid_pre_y: got %0d want 1", y_cnt); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if ({rgb_data, pixel_valid, x_cnt, y_cnt, frame_start, frame_done, line_err} !== 41'd0) begin
            n_fail++; $display("FAIL rstmid_async: got rgb=%h pv=%b x=%0d y=%0d fs=%b fd=%b err=%b want all 0",
                               rgb_data, pixel_valid, x_cnt, y_cnt, frame_start, frame_done, line_err);
        end
        href = 1'b0;
        d = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        fd0 = fd_cnt;
        send_line(2 * H, 0, 0);
        end_frame();
        n_tests++; if (obs_q.size() != 0 || fd_cnt != fd0) begin
            n_fail++; $display("FAIL rstmid_idle: got strobes=%0d done=%0d want 0 0", obs_q.size(), fd_cnt - fd0);
        end
        send_frame(0);
        send_frame(0);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_skip: got %0d want 0", obs_q.size()); end
        send_frame(1);
        n_tests++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL rstmid_pixel: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_vsync_abort();
        pix_t       e, o, p;
        logic [7:0] b, first;
        int         fd0;
        exp_q.delete(); obs_q.delete();
        fd0 = fd_cnt;
        first = 8'd0;
        start_frame();
        send_line(2 * H, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            href = 1'b1;
            d = b;
            if (i % 2 == 0) begin
                first = b;
            end else begin
                p.rgb = {4'h0, first[3:0], b}; p.x = 10'(i / 2); p.y = 9'd1; p.fs = 1'b0;
                exp_q.push_back(p);
            end
        end
        @(negedge clk);
        n_tests++; if (y_cnt !== 9'd1) begin n_fail++; $display("FAIL abort_pre_y: got %0d want 1", y_cnt); end
        vsync = 1'b1;
        d = 8'($urandom);
        @(negedge clk);
        href = 1'b0;
        d = 8'd0;
        repeat (6) @(negedge clk);
        n_tests++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL abort_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL abort_pixel: got %h want %h", o, e); end
        end
        n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL abort_fd: got %0d want 1", fd_cnt - fd0); end
        n_tests++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b want 1", line_err); end
        n_tests++; if (y_cnt !== 9'd0) begin n_fail++; $display("FAIL abort_y: got %0d want 0", y_cnt); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_skip_capture();
        test_pixel_format();
        test_odd_line();
        test_enable_drop();
        test_reset_mid();
        test_vsync_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_rgb444_capture.md
Name: cam_rgb444_capture

Overview:
- Upstream stage of the chroma-key mixer.
- Receives the camera's 8-bit parallel RGB444 byte stream (vsync, href, d) and pairs bytes into 16-bit pixels {4'b0000, R[3:0], G[3:0], B[3:0]} with a one-cycle pixel_valid strobe per pixel.
- Also tracks frame and line position, discards a configurable number of settling frames after enable, and flags malformed lines.

Parameters:
- H_ACTIVE, 640, expected pixels per line, used for the line-length check.
- V_ACTIVE, 480, expected lines per frame, used for the frame-length check.
- SKIP_FRAMES, 2, number of whole frames discarded after enable rises (0 allowed).

Ports:
- clk  in  1  camera pixel clock domain; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  capture enable, level; sampled only at frame boundaries.
- vsync  in  1  camera vsync, high during vertical blanking.
- href  in  1  camera href, high while line bytes are valid.
- d  in  8  camera data byte.
- rgb_data  out  16  {4'b0000, R, G, B}, valid when pixel_valid=1.
- pixel_valid  out  1  one-cycle strobe per assembled pixel.
- x_cnt  out  10  index of the pixel currently on rgb_data (0..H_ACTIVE-1).
- y_cnt  out  9  current line index (0..V_ACTIVE-1).
- frame_start  out  1  one-cycle pulse on the first pixel of a captured frame.
- frame_done  out  1  one-cycle pulse at vsync rise ending a captured frame.
- line_err  out  1  sticky; set on a malformed line or frame, cleared on the next frame_start.

Behaviour:
- Input stage: vsync, href and d are registered once (vs_q, hr_q, d_q). All edge detection uses vs_q against its previous value (vs_q2).
- Reset values: every output 0; state IDLE; skip counter 0; byte phase 0.
- State IDLE:
  - If enable=1 and a vsync falling edge occurs: go to SKIP if SKIP_FRAMES>0, else ACTIVE.
- State SKIP:
  - Each vsync rising edge increments the skip counter.
  - When the counter reaches SKIP_FRAMES, go to WAIT.
  - No pixel_valid is produced.
- State WAIT:
  - On a vsync falling edge: go to ACTIVE if enable=1, else IDLE.
- State ACTIVE, byte pairing:
  - While hr_q=1, the byte phase toggles every cycle.
  - Phase 0 latches d_q[3:0] as R.
  - Phase 1 loads rgb_data={4'b0000, R, d_q[7:4], d_q[3:0]}, pulses pixel_valid, and sets x_cnt to the pixel index.
- Latency: pixel_valid is high in the cycle after the edge that registers the second byte, i.e. 2 clk edges after the second byte is on d.
- Line end (hr_q falling edge):
  - If byte phase=1, the partial pixel is dropped and line_err is set.
  - If the pixel count is not H_ACTIVE, line_err is set.
  - y_cnt increments; the byte phase and pixel counter reset.
- frame_start: coincides with the pixel_valid of pixel (0,0).
- Frame end (vsync rising edge in ACTIVE):
  - frame_done pulses 1 cycle.
  - If y_cnt is not V_ACTIVE, line_err is set.
  - y_cnt returns to 0 and the state goes to WAIT.
- enable=0 mid-frame: the current frame completes normally, then WAIT exits to IDLE. A new enable rise re-runs SKIP.
- vsync rise while href is high: the line is aborted, line_err is set, and frame_done still pulses.
- Counters saturate: x_cnt at 1023, y_cnt at 511. No wrap.
- rst asserted mid-operation: all state, counters and outputs clear immediately. pixel_valid does not glitch high on release.
- rgb_data holds its last value between strobes. Consumers use pixel_valid only.

Test Plan:
- Reset, then enable=1, SKIP_FRAMES=2, three well-formed 4x2 frames (H_ACTIVE=4, V_ACTIVE=2) -> no pixel_valid in frames 1-2. Frame 3 yields exactly 8 strobes, frame_start on the first, one frame_done, line_err=0.
- Bytes 0x0A,0x5C -> rgb_data=16'h0A5C. Bytes 0xFF,0x3E -> 16'h0F3E (upper nibble of the first byte ignored). pixel_valid exactly 2 edges after the second byte.
- Line with 7 bytes (odd count) -> 3 strobes, partial pixel dropped, line_err=1 until the next frame_start.
- enable dropped mid-frame 3 -> frame 3 completes with all 8 strobes and frame_done, then nothing until enable rises again, followed by 2 skipped frames.
- rst pulled low during the second line of a captured frame -> all outputs 0 within the same cycle (asynchronous). After release, capture resumes only via IDLE->SKIP on the next vsync fall.
- vsync rises while href=1 after 2 pixels -> frame_done pulses, line_err=1, y_cnt returns to 0.
